// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Results are registered and announced with a one-cycle done pulse.
module divider #(
    parameter int DIVIDEND_W = 6,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_q;
    logic [DIVIDEND_W-1:0]  dvd_q;
    logic [DIVISOR_W-1:0]   dvs_q;
    logic [DIVISOR_W:0]     r_q;
    logic [DIVIDEND_W-1:0]  q_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   dz_q;
    logic [DIVIDEND_W-1:0]  quot_q;
    logic [DIVISOR_W-1:0]   rem_q;
    logic                   dbz_q;
    logic                   busy_q;
    logic                   done_q;

    logic [DIVISOR_W:0]     r_sh;
    logic                   ge;
    logic [DIVISOR_W:0]     r_d;
    logic [DIVIDEND_W-1:0]  q_d;

    // R is one bit wider than the divisor: the shifted value can reach 2*divisor-1.
    always_comb begin
        r_sh = {r_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
        ge   = (r_sh >= {1'b0, dvs_q});
        r_d  = ge ? (r_sh - {1'b0, dvs_q}) : r_sh;
        q_d  = {q_q[DIVIDEND_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q   <= dividend;
                        dvs_q   <= divisor;
                        r_q     <= '0;
                        q_q     <= '0;
                        cnt_q   <= '0;
                        dz_q    <= (divisor == '0);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    // A zero divisor skips the iterations and spends a single cycle here.
                    if (dz_q) begin
                        quot_q  <= '1;
                        rem_q   <= '0;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        r_q   <= r_d;
                        q_q   <= q_d;
                        dvd_q <= dvd_q << 1;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            quot_q  <= q_d;
                            rem_q   <= r_d[DIVISOR_W-1:0];
                            dbz_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Bench for the restoring divider: directed cases, exhaustive sweep and random
// operations, all checked against integer division computed in the bench.
module tb_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    divider #(.DIVIDEND_W(6), .DIVISOR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, results and the return to idle.
    task automatic do_div(input string tag, input int a, input int b);
        int eq, er, ez, lat, cyc;
        if (b == 0) begin
            eq = 63; er = 0; ez = 1; lat = 1;
        end else begin
            eq = a / b; er = a % b; ez = 0; lat = 6;
        end
        start    = 1'b1;
        dividend = 6'(a);
        divisor  = 3'(b);
        tick();
        start = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(lat));
        chk({tag, ".quot"}, 32'(quotient), 32'(eq));
        chk({tag, ".rem"}, 32'(remainder), 32'(er));
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
        tick();
        chk({tag, ".done_low"}, 32'(done), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc, ndone, a, b;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.quot", 32'(quotient), 32'd0);
        chk("rst.rem", 32'(remainder), 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        do_div("d42_6", 42, 6);
        do_div("d41_6", 41, 6);
        do_div("d63_7", 63, 7);
        do_div("d5_7", 5, 7);
        do_div("d0_3", 0, 3);
        do_div("d63_1", 63, 1);

        do_div("d12_0", 12, 0);
        do_div("d12_4", 12, 4);

        for (int ia = 0; ia < 64; ia++) begin
            for (int ib = 1; ib < 8; ib++) begin
                do_div("sweep", ia, ib);
                chk("sweep.identity", 32'(int'(quotient) * ib + int'(remainder)), 32'(ia));
                chk("sweep.rem_lt", 32'(int'(remainder) < ib), 32'd1);
            end
        end

        for (int ma = 1; ma < 8; ma++) begin
            for (int mb = 1; mb < 8; mb++) begin
                do_div("product", ma * mb, mb);
                chk("product.back", 32'(quotient), 32'(ma));
            end
        end

        repeat (40) begin
            a = int'($urandom_range(0, 63));
            b = int'($urandom_range(0, 7));
            do_div("random", a, b);
        end

        // Start and operand changes during CALC must not disturb the running operation.
        do_div("pre_ign", 41, 6);
        start    = 1'b1;
        dividend = 6'd42;
        divisor  = 3'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        start    = 1'b1;
        dividend = 6'd63;
        divisor  = 3'd7;
        tick();
        start    = 1'b0;
        dividend = 6'd5;
        divisor  = 3'd1;
        chk("ign.hold_quot", 32'(quotient), 32'd6);
        chk("ign.hold_rem", 32'(remainder), 32'd5);
        chk("ign.busy", 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("ign.latency", 32'(cyc), 32'd3);
        chk("ign.quot", 32'(quotient), 32'd7);
        chk("ign.rem", 32'(remainder), 32'd0);
        chk("ign.dbz", 32'(div_by_zero), 32'd0);
        ndone = 0;
        repeat (12) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("ign.no_second_done", 32'(ndone), 32'd0);
        chk("ign.result_kept", 32'(quotient), 32'd7);

        // Asynchronous reset in the middle of CALC.
        do_div("pre_rst", 41, 6);
        start    = 1'b1;
        dividend = 6'd63;
        divisor  = 3'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.quot", 32'(quotient), 32'd0);
        chk("midrst.rem", 32'(remainder), 32'd0);
        chk("midrst.dbz", 32'(div_by_zero), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("midrst.no_done", 32'(ndone), 32'd0);
        chk("midrst.idle", 32'(busy), 32'd0);
        do_div("post_rst", 63, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
